// File: rtl/snake_pkg.sv
// Shared types and sizes for the snake display/game SRAM subsystem.
// Latency: none (declarations only).
// Backpressure: not applicable.
package snake_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    TURN
  } arb_state_t;

  // Saturating 8-bit increment used by the starvation counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sram_io.sv
// SRAM data-pin handling: dq tristate driver plus per-requester read-capture registers.
// Latency: capture at the edge ending the last access cycle, visible the next cycle.
// Backpressure: none; driven purely by enables from the arbiter FSM.
module sram_io
  import snake_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dq_oe,
  input  logic [SRAM_DATA_W-1:0] wdata,
  input  logic                   cap_vid,
  input  logic                   cap_game,
  inout  wire  [SRAM_DATA_W-1:0] sram_dq,
  output logic [SRAM_DATA_W-1:0] vid_rdata,
  output logic [SRAM_DATA_W-1:0] game_rdata
);

  // The pins are only driven during write accesses; otherwise the SRAM or nobody owns them.
  assign sram_dq = dq_oe ? wdata : {SRAM_DATA_W{1'bz}};

  // Each requester keeps its own last read value until its next read completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      vid_rdata  <= '0;
      game_rdata <= '0;
    end else begin
      if (cap_vid)  vid_rdata  <= sram_dq;
      if (cap_game) game_rdata <= sram_dq;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter onto one async SRAM: video reads vs game read/write, video priority with starvation escape.
// Latency: gnt in the cycle after the request is sampled; rvalid ACCESS_CYCLES cycles after gnt.
// Backpressure: requesters hold req until gnt; a request arriving mid-access waits for the next IDLE.
module sram_arbiter
  import snake_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   vid_req,
  input  logic [SRAM_ADDR_W-1:0] vid_addr,
  output logic                   vid_gnt,
  output logic [SRAM_DATA_W-1:0] vid_rdata,
  output logic                   vid_rvalid,
  input  logic                   game_req,
  input  logic                   game_we,
  input  logic [SRAM_ADDR_W-1:0] game_addr,
  input  logic [SRAM_DATA_W-1:0] game_wdata,
  output logic                   game_gnt,
  output logic [SRAM_DATA_W-1:0] game_rdata,
  output logic                   game_rvalid,
  inout  wire  [SRAM_DATA_W-1:0] sram_dq,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic                   busy
);

  localparam logic [2:0] LAST_CNT  = 3'(ACCESS_CYCLES - 1);
  localparam logic [7:0] STARVE_TH = 8'(STARVE_LIMIT);

  arb_state_t             state;
  arb_state_t             state_nxt;
  logic [2:0]             cyc_cnt;
  logic [2:0]             cyc_cnt_nxt;
  logic                   owner_game;
  logic                   lat_we;
  logic [SRAM_DATA_W-1:0] lat_wdata;
  logic [7:0]             starve_cnt;
  logic                   dq_oe;

  logic                   game_wins;
  logic                   grant_vid;
  logic                   grant_game;
  logic                   cap_vid;
  logic                   cap_game;
  logic                   acc_we;
  logic                   we_n_nxt;
  logic                   oe_n_nxt;
  logic                   dq_oe_nxt;

  // Video has priority unless the game has been waiting long enough.
  assign game_wins = game_req && (!vid_req || (starve_cnt >= STARVE_TH));

  assign busy = (state != IDLE);

  // Next-state, grant/capture decisions and the strobe values for the coming cycle.
  always_comb begin
    state_nxt   = state;
    cyc_cnt_nxt = cyc_cnt;
    grant_vid   = 1'b0;
    grant_game  = 1'b0;
    cap_vid     = 1'b0;
    cap_game    = 1'b0;
    acc_we      = lat_we;
    we_n_nxt    = 1'b1;
    oe_n_nxt    = 1'b1;
    dq_oe_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (game_wins) begin
          grant_game  = 1'b1;
          acc_we      = game_we;
          state_nxt   = ACCESS;
          cyc_cnt_nxt = 3'd0;
        end else if (vid_req) begin
          grant_vid   = 1'b1;
          acc_we      = 1'b0;
          state_nxt   = ACCESS;
          cyc_cnt_nxt = 3'd0;
        end
      end
      ACCESS: begin
        if (cyc_cnt == LAST_CNT) begin
          // Reads sample dq at the edge closing the last access cycle.
          cap_vid   = !lat_we && !owner_game;
          cap_game  = !lat_we && owner_game;
          state_nxt = lat_we ? TURN : IDLE;
        end else begin
          cyc_cnt_nxt = cyc_cnt + 3'd1;
        end
      end
      TURN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Strobes are registered so the async SRAM sees glitch-free control pins.
    // A write releases we_n in its last cycle so address and data are held past the rising edge.
    if (state_nxt == ACCESS) begin
      oe_n_nxt  = acc_we;
      we_n_nxt  = !acc_we || (cyc_cnt_nxt == LAST_CNT);
      dq_oe_nxt = acc_we;
    end
  end

  // FSM state, latched request, registered SRAM pins, grant/rvalid pulses and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cyc_cnt     <= 3'd0;
      owner_game  <= 1'b0;
      lat_we      <= 1'b0;
      lat_wdata   <= '0;
      starve_cnt  <= 8'd0;
      sram_addr   <= '0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      dq_oe       <= 1'b0;
      vid_gnt     <= 1'b0;
      game_gnt    <= 1'b0;
      vid_rvalid  <= 1'b0;
      game_rvalid <= 1'b0;
    end else begin
      state       <= state_nxt;
      cyc_cnt     <= cyc_cnt_nxt;
      sram_we_n   <= we_n_nxt;
      sram_oe_n   <= oe_n_nxt;
      dq_oe       <= dq_oe_nxt;
      vid_gnt     <= grant_vid;
      game_gnt    <= grant_game;
      vid_rvalid  <= cap_vid;
      game_rvalid <= cap_game;

      if (grant_vid) begin
        sram_addr  <= vid_addr;
        lat_we     <= 1'b0;
        owner_game <= 1'b0;
      end else if (grant_game) begin
        sram_addr  <= game_addr;
        lat_we     <= game_we;
        lat_wdata  <= game_wdata;
        owner_game <= 1'b1;
      end

      // Count cycles the game spends waiting; the grant itself resets the count.
      if (grant_game) begin
        starve_cnt <= 8'd0;
      end else if (game_req && !game_gnt) begin
        starve_cnt <= sat_inc8(starve_cnt);
      end
    end
  end

  sram_io u_io (
    .clk        (clk),
    .rst        (rst),
    .dq_oe      (dq_oe),
    .wdata      (lat_wdata),
    .cap_vid    (cap_vid),
    .cap_game   (cap_game),
    .sram_dq    (sram_dq),
    .vid_rdata  (vid_rdata),
    .game_rdata (game_rdata)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural async SRAM on the dq pins.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        vid_req;
  logic [17:0] vid_addr;
  logic        vid_gnt;
  logic [15:0] vid_rdata;
  logic        vid_rvalid;
  logic        game_req;
  logic        game_we;
  logic [17:0] game_addr;
  logic [15:0] game_wdata;
  logic        game_gnt;
  logic [15:0] game_rdata;
  logic        game_rvalid;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem [0:262143];
  logic [15:0] exp_vid_rd;
  logic [15:0] exp_game_rd;

  always #5 clk = ~clk;

  sram_arbiter #(.ACCESS_CYCLES(2), .STARVE_LIMIT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .vid_req     (vid_req),
    .vid_addr    (vid_addr),
    .vid_gnt     (vid_gnt),
    .vid_rdata   (vid_rdata),
    .vid_rvalid  (vid_rvalid),
    .game_req    (game_req),
    .game_we     (game_we),
    .game_addr   (game_addr),
    .game_wdata  (game_wdata),
    .game_gnt    (game_gnt),
    .game_rdata  (game_rdata),
    .game_rvalid (game_rvalid),
    .sram_dq     (sram_dq),
    .sram_addr   (sram_addr),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n),
    .busy        (busy)
  );

  // SRAM model: drives dq on reads, stores dq while we_n is low.
  assign sram_dq = (!sram_oe_n && sram_we_n) ? mem[sram_addr] : 16'bz;

  always @(posedge clk) begin
    if (rst) begin
      mem[18'h00123] <= 16'hBEEF;
      mem[18'h00000] <= 16'h1234;
    end else if (!sram_we_n) begin
      mem[sram_addr] <= sram_dq;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_game;
    logic        we;
    logic [17:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_rv_cyc;
    int          exp_idle_cyc;
    logic        exp_oe_n1;
    logic        exp_we_n1;
    logic        exp_we_n2;
  } vec_t;

  vec_t vecs[6];

  // Single transaction from IDLE; request goes up in cycle 0, trace over cycles 1..6.
  task automatic run_vec(input vec_t v, input string tag);
    int gnt_cyc = 0;
    int gnt_cnt = 0;
    int rv_cyc  = 0;
    int rv_cnt  = 0;
    int idle_cyc = 0;
    logic oe1 = 1'b1;
    logic we1 = 1'b1;
    logic we2 = 1'b1;
    logic [17:0] a1 = '0;
    logic [15:0] dq1 = '0;
    logic [15:0] rd = '0;
    logic g, r;
    if (v.is_game) begin
      game_req = 1'b1; game_we = v.we; game_addr = v.addr; game_wdata = v.wdata;
    end else begin
      vid_req = 1'b1; vid_addr = v.addr;
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      g = v.is_game ? game_gnt : vid_gnt;
      r = v.is_game ? game_rvalid : vid_rvalid;
      if (g) begin
        gnt_cnt++;
        if (gnt_cyc == 0) gnt_cyc = k;
        vid_req = 1'b0;
        game_req = 1'b0;
      end
      if (r) begin
        rv_cnt++;
        if (rv_cyc == 0) rv_cyc = k;
        rd = v.is_game ? game_rdata : vid_rdata;
      end
      if (!busy && idle_cyc == 0) idle_cyc = k;
      if (k == 1) begin oe1 = sram_oe_n; we1 = sram_we_n; a1 = sram_addr; dq1 = sram_dq; end
      if (k == 2) we2 = sram_we_n;
    end
    chk({tag, " gnt_cycle"}, 32'(gnt_cyc), 32'd1);
    chk({tag, " gnt_count"}, 32'(gnt_cnt), 32'd1);
    chk({tag, " rvalid_cycle"}, 32'(rv_cyc), 32'(v.exp_rv_cyc));
    chk({tag, " rvalid_count"}, 32'(rv_cnt), v.we ? 32'd0 : 32'd1);
    chk({tag, " idle_cycle"}, 32'(idle_cyc), 32'(v.exp_idle_cyc));
    chk({tag, " oe_n_c1"}, 32'(oe1), 32'(v.exp_oe_n1));
    chk({tag, " we_n_c1"}, 32'(we1), 32'(v.exp_we_n1));
    chk({tag, " we_n_c2"}, 32'(we2), 32'(v.exp_we_n2));
    chk({tag, " sram_addr_c1"}, 32'(a1), 32'(v.addr));
    if (v.we) begin
      chk({tag, " dq_c1"}, 32'(dq1), 32'(v.wdata));
      chk({tag, " mem_after"}, 32'(mem[v.addr]), 32'(v.wdata));
    end else begin
      chk({tag, " rdata"}, 32'(rd), 32'(v.exp_rdata));
      if (v.is_game) exp_game_rd = v.exp_rdata;
      else exp_vid_rd = v.exp_rdata;
    end
    chk({tag, " vid_rdata_hold"}, 32'(vid_rdata), 32'(exp_vid_rd));
    chk({tag, " game_rdata_hold"}, 32'(game_rdata), 32'(exp_game_rd));
  endtask

  initial begin
    int turn_cyc, vgnt_cyc, oe_cyc, rv_cyc, conflicts;
    int vid_before, game_first, game_cnt, vid_after, grv_cyc;
    logic [15:0] rd;

    vecs[0] = '{1'b0, 1'b0, 18'h00123, 16'h0000, 16'hBEEF, 3, 3, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 1'b1, 18'h3FFFF, 16'h07E0, 16'h0000, 0, 4, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 18'h3FFFF, 16'h0000, 16'h07E0, 3, 3, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 18'h00000, 16'h0000, 16'h1234, 3, 3, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 18'h00010, 16'hA5A5, 16'h0000, 0, 4, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 18'h00010, 16'h0000, 16'hA5A5, 3, 3, 1'b0, 1'b1, 1'b1};

    rst = 1'b1; vid_req = 1'b0; vid_addr = '0;
    game_req = 1'b0; game_we = 1'b0; game_addr = '0; game_wdata = '0;
    exp_vid_rd = '0; exp_game_rd = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst vid_gnt", 32'(vid_gnt), 32'd0);
    chk("rst game_gnt", 32'(game_gnt), 32'd0);
    chk("rst vid_rvalid", 32'(vid_rvalid), 32'd0);
    chk("rst game_rvalid", 32'(game_rvalid), 32'd0);
    chk("rst vid_rdata", 32'(vid_rdata), 32'd0);
    chk("rst game_rdata", 32'(game_rdata), 32'd0);
    chk("rst sram_addr", 32'(sram_addr), 32'd0);
    chk("rst we_n", 32'(sram_we_n), 32'd1);
    chk("rst oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst dq_oe", 32'(dut.dq_oe), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table of single transactions
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Game write immediately followed by a video read of the same word
    game_req = 1'b1; game_we = 1'b1; game_addr = 18'h00200; game_wdata = 16'h5555;
    turn_cyc = 0; vgnt_cyc = 0; oe_cyc = 0; rv_cyc = 0; conflicts = 0; rd = '0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        game_req = 1'b0;
        vid_req = 1'b1; vid_addr = 18'h00200;
      end
      if (!sram_oe_n && dut.dq_oe) conflicts++;
      if (busy && sram_we_n && sram_oe_n && !dut.dq_oe && turn_cyc == 0) turn_cyc = k;
      if (vid_gnt) begin
        if (vgnt_cyc == 0) vgnt_cyc = k;
        vid_req = 1'b0;
      end
      if (!sram_oe_n && oe_cyc == 0) oe_cyc = k;
      if (vid_rvalid) begin rv_cyc = k; rd = vid_rdata; end
    end
    chk("wr2rd contention", 32'(conflicts), 32'd0);
    chk("wr2rd turn_cycle", 32'(turn_cyc), 32'd3);
    chk("wr2rd vid_gnt_cycle", 32'(vgnt_cyc), 32'd5);
    chk("wr2rd first_oe_cycle", 32'(oe_cyc), 32'd5);
    chk("wr2rd rvalid_cycle", 32'(rv_cyc), 32'd7);
    chk("wr2rd rdata", 32'(rd), 32'h5555);
    exp_vid_rd = 16'h5555;

    // Both requesters held: video wins three times, then the starved game gets exactly one grant
    vid_req = 1'b1; vid_addr = 18'h00123;
    game_req = 1'b1; game_we = 1'b0; game_addr = 18'h3FFFF;
    vid_before = 0; game_first = 0; game_cnt = 0; vid_after = 0; grv_cyc = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (vid_gnt && game_first == 0) vid_before++;
      if (vid_gnt && game_first != 0 && vid_after == 0) vid_after = k;
      if (game_gnt) begin
        game_cnt++;
        if (game_first == 0) game_first = k;
      end
      if (game_rvalid) grv_cyc = k;
    end
    vid_req = 1'b0; game_req = 1'b0;
    chk("starve vid_grants_before", 32'(vid_before), 32'd3);
    chk("starve game_gnt_cycle", 32'(game_first), 32'd10);
    chk("starve game_gnt_count", 32'(game_cnt), 32'd1);
    chk("starve game_rvalid_cycle", 32'(grv_cyc), 32'd12);
    chk("starve game_rdata", 32'(game_rdata), 32'h07E0);
    chk("starve vid_gnt_after", 32'(vid_after), 32'd13);
    repeat (4) @(posedge clk);
    #1;
    chk("starve idle_after", 32'(busy), 32'd0);
    exp_vid_rd = 16'hBEEF;
    exp_game_rd = 16'h07E0;

    // Reset in the second access cycle of a video read
    vid_req = 1'b1; vid_addr = 18'h00123;
    @(posedge clk); #1;
    chk("abort vid_gnt_c1", 32'(vid_gnt), 32'd1);
    vid_req = 1'b0;
    @(posedge clk); #1;
    chk("abort oe_n_c2", 32'(sram_oe_n), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort rvalid_c3", 32'(vid_rvalid), 32'd0);
    chk("abort we_n_c3", 32'(sram_we_n), 32'd1);
    chk("abort oe_n_c3", 32'(sram_oe_n), 32'd1);
    chk("abort dq_oe_c3", 32'(dut.dq_oe), 32'd0);
    chk("abort busy_c3", 32'(busy), 32'd0);
    chk("abort vid_rdata_c3", 32'(vid_rdata), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort rvalid_c4", 32'(vid_rvalid), 32'd0);
    exp_vid_rd = '0;
    exp_game_rd = '0;
    run_vec(vecs[0], "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter ACCESS_CYCLES, default 2, meaning the number of cycles the SRAM address and strobes are held per access (legal 2..7).
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 8, meaning the number of waiting cycles after which the game requester beats video (legal 1..255).
REQ-003 The block SHALL have port clk  in  1  system pixel clock (25.2 MHz); all logic is on its rising edge.
REQ-004 The block SHALL have port rst  in  1  one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have ports vid_req in 1, vid_addr in 18, vid_gnt out 1, vid_rdata out 16, vid_rvalid out 1: the display fetch requester, read-only.
REQ-006 The block SHALL have ports game_req in 1, game_we in 1, game_addr in 18, game_wdata in 16, game_gnt out 1, game_rdata out 16, game_rvalid out 1: the snake game-logic requester, read/write.
REQ-007 The block SHALL have ports sram_dq inout 16, sram_addr out 18, sram_we_n out 1, sram_oe_n out 1: the external asynchronous SRAM.
REQ-008 The block SHALL have port busy out 1, high whenever state is not IDLE.

Function
REQ-009 The FSM SHALL have states IDLE, ACCESS and TURN.
REQ-010 In IDLE, at an edge where a request is sampled, the FSM SHALL latch the winner's address, we and wdata, go to ACCESS and pulse the winner's gnt for exactly the first ACCESS cycle.
REQ-011 Arbitration SHALL be fixed video priority, except that game wins when both request and starve_cnt >= STARVE_LIMIT.
REQ-012 starve_cnt SHALL be 8 bits: it increments in each cycle game_req=1 and game_gnt=0, saturates at 255, and clears to 0 in the game_gnt cycle.
REQ-013 Requesters SHALL hold req, addr, we and wdata stable until their gnt; the arbiter ignores these signals in all other cycles.
REQ-014 ACCESS SHALL last exactly ACCESS_CYCLES cycles; sram_addr SHALL equal the latched address throughout.
REQ-015 A read SHALL drive sram_oe_n=0 and sram_we_n=1 throughout ACCESS, with sram_dq hi-Z.
REQ-016 A write SHALL drive sram_dq with the latched wdata throughout ACCESS; sram_we_n=0 in every ACCESS cycle but the last, and 1 in the last (address/data hold); sram_oe_n=1.
REQ-017 For a read, sram_dq SHALL be captured at the end of the last ACCESS cycle; the owner's rdata SHALL update and its rvalid pulse for one cycle in the next cycle.
REQ-018 rdata SHALL hold its value until the next read for that requester.
REQ-019 After a read, ACCESS SHALL return to IDLE; after a write it SHALL go to TURN for one cycle (dq hi-Z, both strobes high) and then to IDLE.
REQ-020 Latency SHALL be fixed: with the request sampled at edge 0 and ACCESS_CYCLES=N, gnt is high in cycle 1 and rvalid in cycle N+1; read throughput is one access per N+1 cycles.
REQ-021 In IDLE and TURN, sram_we_n and sram_oe_n SHALL be 1, sram_dq hi-Z and sram_addr hold its last value.
REQ-022 A request asserted during ACCESS/TURN SHALL wait, with no loss, until the next IDLE arbitration.

Reset
REQ-023 rst SHALL force state IDLE, starve_cnt 0, all gnt/rvalid 0, rdata 0, sram_addr 0, sram_we_n 1, sram_oe_n 1, sram_dq hi-Z and busy 0 at the next edge.
REQ-024 rst during ACCESS SHALL abort the access: no rvalid is issued and a write is cut short with we_n deasserted at that edge.

Structure
REQ-025 A shared package snake_pkg SHALL hold SRAM_ADDR_W=18, SRAM_DATA_W=16 and enum arb_state_t {IDLE, ACCESS, TURN}.
REQ-026 A sub-module sram_io SHALL contain the dq tristate driver and the read-capture register.

Verification
REQ-027 Video read only, N=2: vid_req at edge 0, addr 0x00123 -> vid_gnt cycle 1, oe_n=0 cycles 1-2, vid_rvalid cycle 3 with the model's data 0xBEEF.
REQ-028 Game write, addr 0x3FFFF, data 0x07E0 -> we_n low cycle 1, high cycle 2, dq=0x07E0 cycles 1-2, TURN cycle 3, IDLE cycle 4; the model holds 0x07E0.
REQ-029 vid_req and game_req both held continuously -> video wins until starve_cnt reaches 8, then game_gnt exactly once, starve_cnt=0, and video wins again.
REQ-030 Game write immediately followed by video read -> dq never driven by the arbiter while oe_n=0; a TURN cycle is observed between the two accesses.
REQ-031 rst asserted in the second ACCESS cycle of a read -> no rvalid, strobes high and dq hi-Z at that edge; the next request is served normally.
